// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one multiply-by-10-and-add step per digit, MSD first.
// Latency DIGITS cycles from acceptance to out_valid; DONE holds its result indefinitely while out_ready is low.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [4*DIGITS-1:0]   r_bcd;
    logic [BIN_W-1:0]      r_acc;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;

    logic                  w_accept;
    logic                  w_last;
    logic [IDX_W+1:0]      w_base;
    logic [3:0]            w_nib;
    logic                  w_nib_bad;
    logic [BIN_W+3:0]      w_acc_ext;
    logic [BIN_W+3:0]      w_sum;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_last    = (r_idx == '0);
    assign w_base    = {r_idx, 2'b00};
    assign w_nib     = r_bcd[w_base +: 4];
    assign w_nib_bad = (w_nib > 4'd9);

    // Widened by 4 bits so acc*10 + nib cannot wrap before the final truncation to BIN_W.
    assign w_acc_ext = {4'b0000, r_acc};
    assign w_sum     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{BIN_W{1'b0}}, w_nib};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_CONV;
            ST_CONV: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_acc <= '0;
            r_err <= 1'b0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_bcd <= in_bcd;
            r_acc <= '0;
            r_err <= 1'b0;
            r_idx <= IDX_W'(DIGITS - 1);
        end else if (r_state == ST_CONV) begin
            r_acc <= w_sum[BIN_W-1:0];
            r_err <= r_err | w_nib_bad;
            if (!w_last) begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign out_bin = r_acc;
    assign out_err = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: fixed vectors, handshake timing, backpressure and async reset abort.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one word at the next posedge (E0); with noisy=1 in_valid stays high and in_bcd
    // is scrambled through CONV. out_ready is held high so DONE lasts exactly one cycle.
    task automatic convert(input string tag, input logic [15:0] bcd,
                           input logic [13:0] exp_bin, input logic exp_err, input bit noisy);
        @(negedge clk);
        in_bcd    = bcd;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, ".rdy_pre"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (noisy) in_bcd = 16'($urandom);
            else begin
                in_valid = 1'b0;
                in_bcd   = 16'hxxxx;
            end
            check({tag, ".vld_conv"}, 32'(out_valid), 32'd0);
            check({tag, ".rdy_conv"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".vld_done"}, 32'(out_valid), 32'd1);
        check({tag, ".rdy_done"}, 32'(in_ready), 32'd0);
        check({tag, ".bin"}, 32'(out_bin), 32'(exp_bin));
        check({tag, ".err"}, 32'(out_err), 32'(exp_err));
        @(negedge clk);
        check({tag, ".vld_idle"}, 32'(out_valid), 32'd0);
        check({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = 16'h0000;
        out_ready = 1'b0;
        #1;
        check("rst.vld", 32'(out_valid), 32'd0);
        check("rst.rdy", 32'(in_ready), 32'd1);
        check("rst.bin", 32'(out_bin), 32'd0);
        check("rst.err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        convert("zero", 16'h0000, 14'd0,    1'b0, 1'b0);
        convert("c1234", 16'h1234, 14'd1234, 1'b0, 1'b0);
        convert("c9999", 16'h9999, 14'd9999, 1'b0, 1'b0);
        // ((1*10+2)*10+10)*10+4
        convert("c12a4", 16'h12A4, 14'd1304, 1'b1, 1'b0);
        // 16665 mod 16384
        convert("cffff", 16'hFFFF, 14'd281,  1'b1, 1'b0);
        convert("c0001", 16'h0001, 14'd1,    1'b0, 1'b0);
        convert("noisy", 16'h8076, 14'd8076, 1'b0, 1'b1);

        // Backpressure: DONE holds while out_ready is low, in_valid pulses are ignored.
        @(negedge clk);
        in_bcd    = 16'h0567;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("bp.vld_first", 32'(out_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_bcd   = 16'h0999;
            @(negedge clk);
            check("bp.vld", 32'(out_valid), 32'd1);
            check("bp.bin", 32'(out_bin), 32'd567);
            check("bp.err", 32'(out_err), 32'd0);
            check("bp.rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.vld_rel", 32'(out_valid), 32'd0);
        check("bp.rdy_rel", 32'(in_ready), 32'd1);

        // Async reset between E2 and E3 aborts the conversion.
        @(negedge clk);
        in_bcd   = 16'h5555;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("ar.bin_mid", 32'(out_bin), 32'd55);
        rst_n = 1'b0;
        #1;
        check("ar.vld", 32'(out_valid), 32'd0);
        check("ar.rdy", 32'(in_ready), 32'd1);
        check("ar.bin", 32'(out_bin), 32'd0);
        check("ar.err", 32'(out_err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            check("ar.vld_hold", 32'(out_valid), 32'd0);
        end
        convert("c0042", 16'h0042, 14'd42, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
